memory_writer: RTL and testbench

- Capture-side counterpart of the dual-BRAM memory reader.
- Accepts a stream of paired reference/error samples and writes them into the two block memories through registered port-A signals (ena/wea/addra/dina).
- Fills DATA_DEPTH words per capture: one-shot or continuous ring mode.
- Reports progress and completion to the controlling logic.

---
 rtl/memory_writer_pkg.sv | 19 +
 rtl/mem_write_pointer.sv | 52 +++++
 rtl/memory_writer.sv | 132 +++++++++++++
 tb/tb_memory_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_writer_pkg.sv
// Shared constants, state encoding and pointer-advance helper for the capture writer.
package memory_writer_pkg;

   localparam int unsigned DataSizeDef   = 64;
   localparam int unsigned AddrModuleDef = 10;

   // Legacy-compatible state encoding
   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCapture = 2'd1;
   localparam logic [1:0] StDone    = 2'd2;

   // Returns {wrap, next_ptr}: wrap is set when ptr is the last address of a depth-word buffer
   function automatic logic [32:0] addr_next(input logic [31:0] ptr, input logic [31:0] depth);
      logic wrap;
      wrap = (ptr == depth - 32'd1);
      return {wrap, (wrap ? 32'd0 : ptr + 32'd1)};
   endfunction

endpackage

// File: rtl/mem_write_pointer.sv
// Write pointer and saturating word counter for one capture buffer.
module mem_write_pointer
   import memory_writer_pkg::*;
#(
   parameter int unsigned DATA_DEPTH  = 20,
   parameter int unsigned ADDR_MODULE = AddrModuleDef
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_clear,
   input  logic                   i_advance,
   output logic [ADDR_MODULE-1:0] o_ptr,
   output logic [ADDR_MODULE:0]   o_count,
   output logic                   o_at_last
);

   logic [ADDR_MODULE-1:0] ptr_q;
   logic [ADDR_MODULE:0]   count_q;
   logic [32:0]            nxt;
   logic                   count_full;
   logic                   unused_nxt;

   // Next pointer and wrap flag from the shared helper
   always_comb begin
      nxt        = addr_next(32'(ptr_q), 32'(DATA_DEPTH));
      // Compared at ADDR_MODULE+1 bits so a full 2**ADDR_MODULE buffer is representable
      count_full = (count_q == (ADDR_MODULE + 1)'(DATA_DEPTH));
   end

   assign unused_nxt = ^nxt[31:ADDR_MODULE];

   // Pointer wraps to 0 after the last address; count saturates at DATA_DEPTH
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (i_clear) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (i_advance) begin
         ptr_q <= nxt[ADDR_MODULE-1:0];
         if (!count_full) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign o_ptr     = ptr_q;
   assign o_count   = count_q;
   assign o_at_last = nxt[32];

endmodule

// File: rtl/memory_writer.sv
// Captures paired reference/error samples into two block memories via registered port A.
module memory_writer
   import memory_writer_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = DataSizeDef,
   parameter int unsigned DATA_DEPTH  = 20,
   parameter int unsigned ADDR_MODULE = AddrModuleDef,
   parameter int unsigned CONTINUOUS  = 0
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic                   i_valid,
   input  logic [DATA_SIZE-1:0]   i_reference,
   input  logic [DATA_SIZE-1:0]   i_error,
   output logic                   o_ready,
   output logic                   o_ena,
   output logic                   o_wea,
   output logic [ADDR_MODULE-1:0] o_addra,
   output logic [DATA_SIZE-1:0]   o_dina_reference,
   output logic [DATA_SIZE-1:0]   o_dina_error,
   output logic [ADDR_MODULE:0]   o_count,
   output logic                   o_wrapped,
   output logic                   o_done
);

   logic [1:0]             state_q, state_d;
   logic                   accept;
   logic                   clear;
   logic                   at_last;
   logic [ADDR_MODULE-1:0] ptr;
   logic                   wea_q;
   logic [ADDR_MODULE-1:0] addra_q;
   logic [DATA_SIZE-1:0]   dina_ref_q;
   logic [DATA_SIZE-1:0]   dina_err_q;
   logic                   wrapped_q;

   mem_write_pointer #(
      .DATA_DEPTH  (DATA_DEPTH),
      .ADDR_MODULE (ADDR_MODULE)
   ) u_ptr (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (clear),
      .i_advance (accept),
      .o_ptr     (ptr),
      .o_count   (o_count),
      .o_at_last (at_last)
   );

   // Next state, accept and clear decode; abort beats valid and start outside IDLE
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      clear   = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StCapture;
               clear   = 1'b1;
            end
         end
         StCapture: begin
            if (i_abort) begin
               state_d = StIdle;
            end else if (i_valid) begin
               accept = 1'b1;
               if (at_last && (CONTINUOUS == 0)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (i_abort) begin
               state_d = StIdle;
            end else if (i_start) begin
               state_d = StCapture;
               clear   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Port-A registers: one write strobe per accepted sample, address/data hold otherwise
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wea_q      <= 1'b0;
         addra_q    <= '0;
         dina_ref_q <= '0;
         dina_err_q <= '0;
      end else begin
         wea_q <= accept;
         if (accept) begin
            addra_q    <= ptr;
            dina_ref_q <= i_reference;
            dina_err_q <= i_error;
         end
      end
   end

   // Sticky wrap flag, only reachable in continuous mode
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wrapped_q <= 1'b0;
      end else if (clear) begin
         wrapped_q <= 1'b0;
      end else if (accept && at_last && (CONTINUOUS != 0)) begin
         wrapped_q <= 1'b1;
      end
   end

   assign o_ready          = (state_q == StCapture);
   assign o_done           = (state_q == StDone);
   assign o_ena            = wea_q;
   assign o_wea            = wea_q;
   assign o_addra          = addra_q;
   assign o_dina_reference = dina_ref_q;
   assign o_dina_error     = dina_err_q;
   assign o_wrapped        = wrapped_q;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer: one-shot instance plus a continuous-mode instance.
module tb_memory_writer;

   localparam int unsigned DS = 64;
   localparam int unsigned DD = 20;
   localparam int unsigned AM = 10;

   logic          clk;
   logic          rst;
   logic          start, abort, valid;
   logic [DS-1:0] refv, errv;

   logic          ready, ena, wea, wrapped, done;
   logic [AM-1:0] addra;
   logic [DS-1:0] dref, derr;
   logic [AM:0]   count;

   logic          c_ready, c_ena, c_wea, c_wrapped, c_done;
   logic [AM-1:0] c_addra;
   logic [DS-1:0] c_dref, c_derr;
   logic [AM:0]   c_count;

   int unsigned checks;
   int unsigned errors;

   logic [AM-1:0] wr_log[$];
   logic [AM-1:0] wrc_log[$];

   memory_writer #(
      .DATA_SIZE(DS), .DATA_DEPTH(DD), .ADDR_MODULE(AM), .CONTINUOUS(0)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_valid(valid),
      .i_reference(refv), .i_error(errv), .o_ready(ready), .o_ena(ena), .o_wea(wea),
      .o_addra(addra), .o_dina_reference(dref), .o_dina_error(derr), .o_count(count),
      .o_wrapped(wrapped), .o_done(done)
   );

   memory_writer #(
      .DATA_SIZE(DS), .DATA_DEPTH(DD), .ADDR_MODULE(AM), .CONTINUOUS(1)
   ) dut_c (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_valid(valid),
      .i_reference(refv), .i_error(errv), .o_ready(c_ready), .o_ena(c_ena), .o_wea(c_wea),
      .o_addra(c_addra), .o_dina_reference(c_dref), .o_dina_error(c_derr),
      .o_count(c_count), .o_wrapped(c_wrapped), .o_done(c_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Write log, sampled mid-cycle
   always @(negedge clk) begin
      if (wea) wr_log.push_back(addra);
      if (c_wea) wrc_log.push_back(c_addra);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if ({ready, ena, wea, wrapped, done} !== 5'b0 || addra !== '0 || count !== '0 ||
          dref !== '0 || derr !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b ena=%b wea=%b wrapped=%b done=%b addra=%0d count=%0d, required all 0",
                  ready, ena, wea, wrapped, done, addra, count);
      end
      checks++;
      if ({c_ready, c_wea, c_wrapped, c_done} !== 4'b0 || c_count !== '0) begin
         errors++;
         $display("FAIL reset_outputs_c: ready=%b wea=%b wrapped=%b done=%b count=%0d, required 0",
                  c_ready, c_wea, c_wrapped, c_done, c_count);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++;
      if (ready !== 1'b0 || wea !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b wea=%b, required 0 0", ready, wea);
      end
   endtask

   task automatic test_back_to_back();
      wr_log.delete();
      do_start();
      checks++;
      if (ready !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL b2b_armed: ready=%b count=%0d, required 1 0", ready, count);
      end
      for (int k = 0; k < 20; k++) begin
         valid = 1'b1; refv = 64'(k); errv = ~64'(k);
         step();
         checks++;
         if (wea !== 1'b1 || ena !== 1'b1 || addra !== 10'(k) || dref !== 64'(k) ||
             derr !== ~64'(k) || count !== 11'(k + 1)) begin
            errors++;
            $display("FAIL b2b_write[%0d]: wea=%b ena=%b addra=%0d ref=%0h err=%0h count=%0d, required 1 1 %0d %0h %0h %0d",
                     k, wea, ena, addra, dref, derr, count, k, 64'(k), ~64'(k), k + 1);
         end
      end
      valid = 1'b0;
      step();
      checks++;
      if (done !== 1'b1 || ready !== 1'b0 || count !== 11'd20 || wea !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done: done=%b ready=%b count=%0d wea=%b, required 1 0 20 0",
                  done, ready, count, wea);
      end
      checks++;
      if (wr_log.size() != 20) begin
         errors++;
         $display("FAIL b2b_write_count: got %0d writes, required 20", wr_log.size());
      end
   endtask

   task automatic test_gapped();
      wr_log.delete();
      do_start();
      for (int k = 0; k < 20; k++) begin
         valid = 1'b1; refv = 64'(k) + 64'h100; errv = ~(64'(k) + 64'h100);
         step();
         valid = 1'b0;
         checks++;
         if (wea !== 1'b1 || addra !== 10'(k) || dref !== 64'(k) + 64'h100 ||
             count !== 11'(k + 1)) begin
            errors++;
            $display("FAIL gap_write[%0d]: wea=%b addra=%0d ref=%0h count=%0d, required 1 %0d %0h %0d",
                     k, wea, addra, dref, count, k, 64'(k) + 64'h100, k + 1);
         end
         for (int g = 0; g < 2; g++) begin
            step();
            checks++;
            if (wea !== 1'b0 || addra !== 10'(k) || count !== 11'(k + 1)) begin
               errors++;
               $display("FAIL gap_idle[%0d]: wea=%b addra=%0d count=%0d, required 0 %0d %0d",
                        k, wea, addra, count, k, k + 1);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || wr_log.size() != 20) begin
         errors++;
         $display("FAIL gap_done: done=%b writes=%0d, required 1 20", done, wr_log.size());
      end
   endtask

   task automatic test_continuous();
      apply_reset();
      wrc_log.delete();
      do_start();
      for (int k = 0; k < 25; k++) begin
         valid = 1'b1; refv = 64'(k); errv = ~64'(k);
         step();
         checks++;
         if (c_wea !== 1'b1 || c_addra !== 10'(k % 20) || c_dref !== 64'(k) ||
             c_count !== 11'((k < 19) ? k + 1 : 20) || c_wrapped !== (k >= 19)) begin
            errors++;
            $display("FAIL cont_write[%0d]: wea=%b addra=%0d ref=%0h count=%0d wrapped=%b, required 1 %0d %0h %0d %b",
                     k, c_wea, c_addra, c_dref, c_count, c_wrapped, k % 20, 64'(k),
                     (k < 19) ? k + 1 : 20, (k >= 19));
         end
      end
      valid = 1'b0;
      step();
      checks++;
      if (c_done !== 1'b0 || c_ready !== 1'b1 || c_count !== 11'd20 || wrc_log.size() != 25) begin
         errors++;
         $display("FAIL cont_end: done=%b ready=%b count=%0d writes=%0d, required 0 1 20 25",
                  c_done, c_ready, c_count, wrc_log.size());
      end
   endtask

   task automatic test_abort();
      apply_reset();
      wr_log.delete();
      do_start();
      for (int k = 0; k < 7; k++) begin
         valid = 1'b1; refv = 64'(k); errv = ~64'(k);
         step();
      end
      abort = 1'b1; refv = 64'd7;
      checks++;
      if (wea !== 1'b1 || addra !== 10'd6) begin
         errors++;
         $display("FAIL abort_inflight: wea=%b addra=%0d, required 1 6", wea, addra);
      end
      step();
      abort = 1'b0; valid = 1'b0;
      checks++;
      if (wea !== 1'b0 || ready !== 1'b0 || count !== 11'd7 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: wea=%b ready=%b count=%0d done=%b, required 0 0 7 0",
                  wea, ready, count, done);
      end
      step();
      checks++;
      if (wr_log.size() != 7 || wr_log[wr_log.size() - 1] !== 10'd6) begin
         errors++;
         $display("FAIL abort_writes: writes=%0d, required 7 ending at address 6", wr_log.size());
      end
      do_start();
      checks++;
      if (ready !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL abort_restart: ready=%b count=%0d, required 1 0", ready, count);
      end
      valid = 1'b1; refv = 64'hAA; errv = 64'h55;
      step();
      valid = 1'b0;
      checks++;
      if (wea !== 1'b1 || addra !== 10'd0 || count !== 11'd1 || dref !== 64'hAA) begin
         errors++;
         $display("FAIL abort_first: wea=%b addra=%0d count=%0d ref=%0h, required 1 0 1 aa",
                  wea, addra, count, dref);
      end
   endtask

   task automatic test_ignored();
      apply_reset();
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (wea !== 1'b0 || ready !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL idle_valid[%0d]: wea=%b ready=%b count=%0d, required 0 0 0",
                     i, wea, ready, count);
         end
      end
      valid = 1'b0;
      do_start();
      valid = 1'b1; refv = 64'd1;
      step();
      valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (ready !== 1'b1 || count !== 11'd1 || wea !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_in_capture: ready=%b count=%0d wea=%b done=%b, required 1 1 0 0",
                  ready, count, wea, done);
      end
      valid = 1'b1;
      for (int k = 1; k < 20; k++) step();
      valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (wea !== 1'b0 || done !== 1'b1 || count !== 11'd20) begin
            errors++;
            $display("FAIL done_valid[%0d]: wea=%b done=%b count=%0d, required 0 1 20",
                     i, wea, done, count);
         end
      end
      valid = 1'b0; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      checks++;
      if (done !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL done_start_abort: done=%b ready=%b, required 0 0", done, ready);
      end
      do_start();
      checks++;
      if (ready !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL idle_restart: ready=%b count=%0d, required 1 0", ready, count);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      do_start();
      valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         refv = 64'(k + 9); errv = 64'(k + 3);
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({ready, ena, wea, wrapped, done} !== 5'b0 || addra !== '0 || count !== '0 ||
          dref !== '0 || derr !== '0 || c_wea !== 1'b0 || c_count !== '0) begin
         errors++;
         $display("FAIL async_reset: ready=%b ena=%b wea=%b addra=%0d count=%0d ref=%0h, required all 0",
                  ready, ena, wea, addra, count, dref);
      end
      #1;
      rst = 1'b0;
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (wea !== 1'b0 || ready !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL post_reset[%0d]: wea=%b ready=%b count=%0d, required 0 0 0",
                     i, wea, ready, count);
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
      refv = '0; errv = '0;
      test_reset();
      test_back_to_back();
      test_gapped();
      test_continuous();
      test_abort();
      test_ignored();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1);
   end

endmodule
